// File: rtl/column_window_buffer_pkg.sv
// Shared constants and types for the 3-row vertical column window buffer.
package column_window_buffer_pkg;

  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned IMG_WIDTH_MAX = 2048;
  localparam int unsigned CNT_W         = $clog2(IMG_WIDTH_MAX);

  // Row fill progress since frame start; STREAM means rows r-1 and r-2 are present.
  typedef enum logic [1:0] {
    ROW_FILL0  = 2'd0,
    ROW_FILL1  = 2'd1,
    ROW_STREAM = 2'd2
  } row_state_e;

endpackage

// File: rtl/line_ram.sv
// Single-row line memory: asynchronous read, synchronous write, same address.
module line_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 640,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Read returns the pre-write contents of the addressed location.
  assign rdata_c = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

endmodule

// File: rtl/column_window_buffer.sv
// Turns a raster pixel stream into vertical 3-pixel columns (rows r-2, r-1, r)
// behind a single ready/valid output register.
module column_window_buffer
  import column_window_buffer_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned IMG_WIDTH = 640
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sof,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [DATA_W-1:0] Pixel_1,
  output logic [DATA_W-1:0] Pixel_2,
  output logic [DATA_W-1:0] Pixel_3,
  output logic              col_valid,
  input  logic              col_ready,
  output logic              col_last
);

  localparam int unsigned    RAM_AW = $clog2(IMG_WIDTH);
  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(IMG_WIDTH - 1);

  logic [CNT_W-1:0]  x_q, x_d;
  row_state_e        row_q, row_d;
  logic              col_valid_q, col_valid_d;
  logic              col_last_q, col_last_d;
  logic [DATA_W-1:0] pix1_q, pix1_d;
  logic [DATA_W-1:0] pix2_q, pix2_d;
  logic [DATA_W-1:0] pix3_q, pix3_d;

  logic              accept_c;
  logic [CNT_W-1:0]  x_cur_c;
  row_state_e        row_cur_c;
  logic [DATA_W-1:0] r1_rdata_c;
  logic [DATA_W-1:0] r2_rdata_c;

  assign pix_ready = !col_valid_q || col_ready;
  assign accept_c  = pix_valid && pix_ready;

  // An accepted sof pixel is always column 0 of fill row 0.
  assign x_cur_c   = sof ? '0 : x_q;
  assign row_cur_c = sof ? ROW_FILL0 : row_q;

  line_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_WIDTH),
    .ADDR_W (RAM_AW)
  ) u_line_r1 (
    .clk     (clk),
    .we      (accept_c),
    .addr    (x_cur_c[RAM_AW-1:0]),
    .wdata   (pix_in),
    .rdata_c (r1_rdata_c)
  );

  line_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_WIDTH),
    .ADDR_W (RAM_AW)
  ) u_line_r2 (
    .clk     (clk),
    .we      (accept_c),
    .addr    (x_cur_c[RAM_AW-1:0]),
    .wdata   (r1_rdata_c),
    .rdata_c (r2_rdata_c)
  );

  always_comb begin
    x_d         = x_q;
    row_d       = row_q;
    col_valid_d = col_valid_q && !col_ready;
    col_last_d  = col_last_q;
    pix1_d      = pix1_q;
    pix2_d      = pix2_q;
    pix3_d      = pix3_q;

    if (accept_c) begin
      if (x_cur_c == X_LAST) begin
        x_d = '0;
        case (row_cur_c)
          ROW_FILL0:  row_d = ROW_FILL1;
          ROW_FILL1:  row_d = ROW_STREAM;
          ROW_STREAM: row_d = ROW_STREAM;
          default:    row_d = ROW_FILL0;
        endcase
      end else begin
        x_d   = x_cur_c + CNT_W'(1);
        row_d = row_cur_c;
      end

      // Columns exist only once two complete rows sit in the line memories.
      if (row_cur_c == ROW_STREAM) begin
        col_valid_d = 1'b1;
        col_last_d  = (x_cur_c == X_LAST);
        pix1_d      = r2_rdata_c;
        pix2_d      = r1_rdata_c;
        pix3_d      = pix_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      row_q       <= ROW_FILL0;
      col_valid_q <= 1'b0;
      col_last_q  <= 1'b0;
      pix1_q      <= '0;
      pix2_q      <= '0;
      pix3_q      <= '0;
    end else begin
      x_q         <= x_d;
      row_q       <= row_d;
      col_valid_q <= col_valid_d;
      col_last_q  <= col_last_d;
      pix1_q      <= pix1_d;
      pix2_q      <= pix2_d;
      pix3_q      <= pix3_d;
    end
  end

  assign col_valid = col_valid_q;
  assign col_last  = col_last_q;
  assign Pixel_1   = pix1_q;
  assign Pixel_2   = pix2_q;
  assign Pixel_3   = pix3_q;

endmodule

// File: tb/tb_column_window_buffer.sv
// Bench for column_window_buffer: raster-history window model plus directed literals.
module tb_column_window_buffer;

  localparam int W  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sof = 1'b0;
  logic [DW-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [DW-1:0] Pixel_1, Pixel_2, Pixel_3;
  logic          col_valid;
  logic          col_ready = 1'b1;
  logic          col_last;

  column_window_buffer #(.DATA_W(DW), .IMG_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sof       (sof),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .Pixel_1   (Pixel_1),
    .Pixel_2   (Pixel_2),
    .Pixel_3   (Pixel_3),
    .col_valid (col_valid),
    .col_ready (col_ready),
    .col_last  (col_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rnd_on = 1'b0;

  // Model: pixels accepted since last sof/reset; expected pending column queue.
  int hist[$];
  int eq1[$], eq2[$], eq3[$], eql[$];
  // Log of columns transferred downstream.
  int lg1[$], lg2[$], lg3[$], lgl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Per-cycle compare against the window model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_col_valid", int'(col_valid), 0);
      chk("rst_pixels", int'({Pixel_1, Pixel_2, Pixel_3}), 0);
      chk("rst_col_last", int'(col_last), 0);
      chk("rst_pix_ready", int'(pix_ready), 1);
      hist.delete();
      eq1.delete(); eq2.delete(); eq3.delete(); eql.delete();
    end else begin
      chk("pix_ready", int'(pix_ready), (eq1.size() == 0 || col_ready) ? 1 : 0);
      chk("col_valid", int'(col_valid), (eq1.size() > 0) ? 1 : 0);
      if (eq1.size() > 0) begin
        chk("pixel_1", int'(Pixel_1), eq1[0]);
        chk("pixel_2", int'(Pixel_2), eq2[0]);
        chk("pixel_3", int'(Pixel_3), eq3[0]);
        chk("col_last", int'(col_last), eql[0]);
        if (col_ready) begin
          lg1.push_back(eq1[0]); lg2.push_back(eq2[0]);
          lg3.push_back(eq3[0]); lgl.push_back(eql[0]);
          void'(eq1.pop_front()); void'(eq2.pop_front());
          void'(eq3.pop_front()); void'(eql.pop_front());
        end
      end
      if (pix_valid && (eq1.size() == 0 || col_ready)) begin
        int n;
        if (sof) hist.delete();
        n = hist.size();
        if (n >= 2 * W) begin
          eq1.push_back(hist[n - 2 * W]);
          eq2.push_back(hist[n - W]);
          eq3.push_back(int'(pix_in));
          eql.push_back(((n % W) == W - 1) ? 1 : 0);
        end
        hist.push_back(int'(pix_in));
      end
    end
  end

  task automatic send(input int v, input bit s);
    pix_in = DW'(v);
    sof = s;
    pix_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pix_ready) begin
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        sof = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: pixel %0d not accepted within 200 cycles", v);
    pix_valid = 1'b0;
    sof = 1'b0;
  endtask

  task automatic do_reset();
    pix_valid = 1'b0;
    sof = 1'b0;
    col_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    lg1.delete(); lg2.delete(); lg3.delete(); lgl.delete();
  endtask

  task automatic chk_log(input string name, input int k, input int p1, input int p2,
                         input int p3, input int last);
    if (lg1.size() > k) begin
      chk({name, "_p1"}, lg1[k], p1);
      chk({name, "_p2"}, lg2[k], p2);
      chk({name, "_p3"}, lg3[k], p3);
      chk({name, "_last"}, lgl[k], last);
    end else begin
      chk({name, "_present"}, lg1.size(), k + 1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    int stall_ok;

    // Basic stream; a stray sof without pix_valid after pixel 6 must be ignored.
    do_reset();
    clear_log();
    for (int v = 1; v <= 12; v++) begin
      send(v, v == 1);
      if (v == 6) begin
        sof = 1'b1;
        idle(1);
        sof = 1'b0;
      end
    end
    idle(3);
    chk("t1_ncols", lg1.size(), 4);
    for (int k = 0; k < 4; k++) chk_log("t1_col", k, k + 1, k + 5, k + 9, (k == 3) ? 1 : 0);

    // Downstream stall on column (2,6,10).
    do_reset();
    clear_log();
    stall_ok = 0;
    fork
      begin
        for (int v = 1; v <= 12; v++) send(v, v == 1);
      end
      begin
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
          @(negedge clk);
          if (col_valid && Pixel_3 == 8'd9) found = 1'b1;
        end
        chk("t2_found_col9", int'(found), 1);
        @(posedge clk);
        #1;
        col_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (!pix_ready && col_valid && Pixel_1 == 8'd2 && Pixel_2 == 8'd6 && Pixel_3 == 8'd10)
            stall_ok++;
        end
        @(posedge clk);
        #1;
        col_ready = 1'b1;
      end
    join
    idle(3);
    chk("t2_stall_cycles", stall_ok, 3);
    chk("t2_ncols", lg1.size(), 4);
    for (int k = 0; k < 4; k++) chk_log("t2_col", k, k + 1, k + 5, k + 9, (k == 3) ? 1 : 0);

    // Mid-frame sof restarts the two-row fill.
    do_reset();
    clear_log();
    for (int v = 1; v <= 6; v++) send(v, v == 1);
    for (int v = 100; v <= 111; v++) send(v, v == 100);
    idle(3);
    chk("t3_ncols", lg1.size(), 4);
    chk_log("t3_first", 0, 100, 104, 108, 0);
    chk_log("t3_last", 3, 103, 107, 111, 1);

    // Reset pulse mid-row 2 drops the pending column and all fill progress.
    do_reset();
    clear_log();
    for (int v = 1; v <= 10; v++) send(v, v == 1);
    rst_n = 1'b0;
    #1;
    chk("t4_async_valid", int'(col_valid), 0);
    chk("t4_async_pixels", int'({Pixel_1, Pixel_2, Pixel_3}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("t4_ncols_before", lg1.size(), 1);
    clear_log();
    for (int v = 20; v <= 31; v++) send(v, 1'b0);
    idle(3);
    chk("t4_ncols_after", lg1.size(), 4);
    chk_log("t4_first", 0, 20, 24, 28, 0);

    // Random handshakes over three 4x6 frames.
    do_reset();
    clear_log();
    rnd_on = 1'b1;
    fork
      begin
        for (int f = 0; f < 3; f++) begin
          for (int i = 0; i < W * 6; i++) begin
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
            send(int'($urandom_range(0, 255)), i == 0);
          end
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          col_ready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    col_ready = 1'b1;
    idle(4);
    chk("t5_ncols", lg1.size(), 3 * 4 * W);

    // Full throughput with both sides held ready.
    clear_log();
    t0 = cyc;
    for (int i = 0; i < W * 6; i++) send(200 - i, i == 0);
    chk("t5_throughput", cyc - t0, W * 6);
    idle(3);
    chk("t5_full_ncols", lg1.size(), 4 * W);
    chk_log("t5_full_first", 0, 200, 196, 192, 0);
    chk("end_queue_empty", eq1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
